ap_itof_f32: RTL and testbench
==============================

# ap_itof_f32

Sequential signed-integer to IEEE-754 single-precision converter. It is the encoding counterpart of the float arithmetic units in the ScalaPipe HDL library: it produces the 32-bit float operands that `ap_addF32`, `ap_mulF32` and the other float units consume. It uses the same operand/result/ready convention as the other `ap_*` units. Normalisation is iterative, one bit per cycle, which keeps the area small.

## Interface
Parameters:
- `WIDTH`, default 32: width of the two's-complement integer input; legal range 2..64.

Ports:
- `clk`, input, 1: single clock; all state changes on its rising edge.
- `rst`, input, 1: asynchronous, active-low reset. Low starts a new conversion; release begins computation.
- `a`, input, WIDTH: signed integer operand; sampled only on the LOAD edge.
- `result`, output, 32: float32 result `{sign, exp[7:0], mant[22:0]}`.
- `ready`, output, 1: result valid; stays high until the next reset.

## Operation
- **Reset (rst low, asynchronous).**
  - state = LOAD; `result` = 32'h0; `ready` = 0.
  - Internal sign, magnitude and exponent are cleared.
- **LOAD (first edge with rst high).**
  - sign = a[WIDTH-1].
  - mag = |a| as a WIDTH-bit unsigned value; the most-negative input gives mag = 2^(WIDTH-1).
  - exp = 127 + WIDTH - 1, held in a 9-bit register.
  - Next state: ROUND if mag == 0 or mag[WIDTH-1] == 1, else NORM.
- **NORM.**
  - Each edge: mag <= mag << 1; exp <= exp - 1.
  - Leave for ROUND once the shifted mag[WIDTH-1] == 1.
- **ROUND (one edge).**
  - Field extraction:
    - mant = mag[WIDTH-2 -: 23], zero-padded on the right when WIDTH < 24.
    - guard = next bit below mant.
    - sticky = OR of all remaining lower bits.
  - Round to nearest, ties to even: increment when guard & (sticky | mant[0]).
  - Mantissa carry-out: mant = 0 and exp = exp + 1.
  - mag == 0 writes `result` = 32'h0, i.e. +0.0; there is never a -0.0 result.
  - Registers `result` and sets `ready` = 1. Next state DONE.
- **DONE.** Holds `result` and `ready`; ignores `a`. Only reset leaves DONE.
- **Range.** WIDTH ≤ 64 keeps the exponent at or below 190, so no overflow, infinity or denormal case exists.
- **Operand stability.** Changes on `a` after the LOAD edge have no effect.

## Timing
- Let L = number of leading zeros of mag, with L = 0 when mag == 0.
- `ready` rises immediately after rising edge number 2 + L following reset release; there is no combinational path to `ready`.
- Latency bounds, WIDTH = 32: best case 2 edges (zero, or |a| ≥ 2^31); worst case 33 edges (a = ±1).
- **Reset in any state, including mid-NORM.** `ready` and `result` drop to 0 asynchronously. The conversion is abandoned and restarts on release.
- **Reset released and reasserted within one cycle.** No LOAD occurs and the outputs stay at their reset values.
- `result` changes only on the ROUND edge and on reset.

## Structure
- Shared package `ap_f32_pkg`:
  - F32_BIAS = 127, F32_EXP_W = 8, F32_MANT_W = 23.
  - State encoding LOAD/NORM/ROUND/DONE.
  - This package is reused by the planned `ap_ftoi_f32`.
- One natural sub-module, `ap_round_f32`: purely combinational.
  - Inputs: 24-bit {mant, guard} plus sticky, and a 9-bit exponent.
  - Outputs: rounded mantissa and adjusted exponent.
  - It is shared with the other float units.
- The top level holds the FSM, the magnitude shift register and the exponent counter.

## Test plan
All cases use WIDTH = 32. Each case asserts `rst` low for one cycle, applies the operand, and counts edges until `ready` rises.
- a = 0 -> result 32'h00000000; ready after 2 edges.
- a = 1 -> 32'h3F800000, ready after 33 edges. a = -1 -> 32'hBF800000, ready after 33 edges.
- a = -2147483648 -> 32'hCF000000; ready after 2 edges.
- Tie to even:
  - a = 16777217 -> 32'h4B800000.
  - a = 16777219 -> 32'h4B800002.
- Mantissa carry-out: a = 2147483647 -> 32'h4F000000.
- Mid-operation reset:
  - Start a = 1; pull rst low after edge 10; `ready` stays 0 and `result` = 0.
  - Release with a = 5 -> 32'h40A00000 after 31 edges.
  - Also compare 100 random `a` values against `$itor` converted to float32.

Source files
------------

// File: rtl/ap_f32_pkg.sv
// Shared float32 constants and converter state encoding.
package ap_f32_pkg;

    localparam int F32_BIAS   = 127;
    localparam int F32_EXP_W  = 8;
    localparam int F32_MANT_W = 23;

    // Converter sequencing: sample operand, normalise, round, hold.
    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_NORM  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } ap_state_e;

endpackage

// File: rtl/ap_itof_f32_if.sv
// Operand/result/ready bundle of the integer-to-float converter.
// Handshake: the operand is taken on the first clock edge after reset
// release; ready rises with a registered result and stays high, result
// stable, until the next reset. There is no back-pressure.
interface ap_itof_f32_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] a;
    logic [31:0]      result;
    logic             ready;

    modport master (output a, input result, input ready);
    modport slave  (input a, output result, output ready);
endinterface

// File: rtl/ap_round_f32.sv
// Round-to-nearest-even of a 23-bit mantissa with guard and sticky bits.
// A carry out of the mantissa renormalises to mantissa 0, exponent + 1.
module ap_round_f32
    import ap_f32_pkg::*;
(
    input  logic [F32_MANT_W:0]   mant_g_i,  // {mant[22:0], guard}
    input  logic                  sticky_i,
    input  logic [8:0]            exp_i,
    output logic [F32_MANT_W-1:0] mant_o,
    output logic [8:0]            exp_o
);

    logic                  guard;
    logic [F32_MANT_W-1:0] mant;
    logic                  inc;
    logic [F32_MANT_W:0]   sum;
    logic                  carry;

    // Increment on above-half, or exactly half with an odd mantissa.
    always_comb begin
        guard  = mant_g_i[0];
        mant   = mant_g_i[F32_MANT_W:1];
        inc    = guard & (sticky_i | mant[0]);
        sum    = {1'b0, mant} + {{F32_MANT_W{1'b0}}, inc};
        carry  = sum[F32_MANT_W];
        mant_o = carry ? '0 : sum[F32_MANT_W-1:0];
        exp_o  = exp_i + {8'd0, carry};
    end

endmodule

// File: rtl/ap_itof_f32.sv
// Sequential signed integer to float32 converter, one normalisation
// shift per cycle. Result and ready are registered.
module ap_itof_f32
    import ap_f32_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,          // asynchronous, active low
    ap_itof_f32_if.slave  io,
    output ap_state_e     dbg_state_o
);

    // Fraction field below the hidden bit, padded so that 23 mantissa bits,
    // a guard bit and at least one sticky bit always exist.
    localparam int         EXT_W    = (WIDTH - 1 < 25) ? 25 : WIDTH - 1;
    localparam int         PAD      = EXT_W - (WIDTH - 1);
    localparam logic [8:0] EXP_INIT = 9'(F32_BIAS + WIDTH - 1);

    ap_state_e        state_q, state_d;
    logic             sign_q, sign_d;
    logic [WIDTH-1:0] mag_q, mag_d;
    logic [8:0]       exp_q, exp_d;
    logic [31:0]      result_q, result_d;

    logic             ld_en, shift_en, round_en, ready;
    logic [WIDTH-1:0] abs_a;
    logic [EXT_W-1:0] frac;
    logic [23:0]      mant_g;
    logic             sticky;
    logic [22:0]      rnd_mant;
    logic [8:0]       rnd_exp;

    // Two's-complement magnitude; the most negative value wraps to 2^(WIDTH-1).
    assign abs_a = io.a[WIDTH-1] ? (~io.a + {{(WIDTH-1){1'b0}}, 1'b1}) : io.a;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_LOAD;
        else      state_q <= state_d;
    end

    // Next-state: normalise until the leading one reaches the top bit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD:  state_d = (abs_a == '0 || abs_a[WIDTH-1]) ? ST_ROUND : ST_NORM;
            ST_NORM:  if (mag_q[WIDTH-2]) state_d = ST_ROUND;
            ST_ROUND: state_d = ST_DONE;
            ST_DONE:  state_d = ST_DONE;
            default:  state_d = ST_LOAD;
        endcase
    end

    // Per-state datapath enables and the ready flag.
    always_comb begin
        ld_en    = 1'b0;
        shift_en = 1'b0;
        round_en = 1'b0;
        ready    = 1'b0;
        case (state_q)
            ST_LOAD:  ld_en    = 1'b1;
            ST_NORM:  shift_en = 1'b1;
            ST_ROUND: round_en = 1'b1;
            ST_DONE:  ready    = 1'b1;
            default:  ;
        endcase
    end

    // Field extraction from the normalised magnitude.
    always_comb begin
        frac   = EXT_W'(mag_q[WIDTH-2:0]) << PAD;
        mant_g = frac[EXT_W-1 -: 24];
        sticky = |frac[EXT_W-25:0];
    end

    ap_round_f32 u_round (
        .mant_g_i (mant_g),
        .sticky_i (sticky),
        .exp_i    (exp_q),
        .mant_o   (rnd_mant),
        .exp_o    (rnd_exp)
    );

    // Datapath next values: load, shift-and-decrement, or round-and-pack.
    always_comb begin
        sign_d   = sign_q;
        mag_d    = mag_q;
        exp_d    = exp_q;
        result_d = result_q;
        if (ld_en) begin
            sign_d = io.a[WIDTH-1];
            mag_d  = abs_a;
            exp_d  = EXP_INIT;
        end
        if (shift_en) begin
            mag_d = {mag_q[WIDTH-2:0], 1'b0};
            exp_d = exp_q - 9'd1;
        end
        if (round_en) begin
            exp_d    = rnd_exp;
            // Zero input always packs as +0.0.
            result_d = (mag_q == '0) ? 32'h0 : {sign_q, rnd_exp[7:0], rnd_mant};
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sign_q   <= 1'b0;
            mag_q    <= '0;
            exp_q    <= '0;
            result_q <= '0;
        end else begin
            sign_q   <= sign_d;
            mag_q    <= mag_d;
            exp_q    <= exp_d;
            result_q <= result_d;
        end
    end

    assign io.result   = result_q;
    assign io.ready    = ready;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ap_itof_f32.sv
// Bench for ap_itof_f32: directed spec cases plus random operands against
// an arithmetic float32 model; a monitor checks result and latency.
module tb_ap_itof_f32;
    import ap_f32_pkg::*;

    localparam int W = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ap_itof_f32_if #(.WIDTH(W)) intf ();
    ap_state_e dbg_state;

    ap_itof_f32 #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .io          (intf.slave),
        .dbg_state_o (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    int          lat_q[$];
    int          edge_cnt;
    bit          seen;

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_f32(input longint v);
        longint m, q, rem, half;
        int     p, sh;
        logic   s;
        s = (v < 0);
        m = s ? -v : v;
        if (m == 0) return 32'h0;
        p = 62;
        while (((m >> p) & 1) == 0) p--;
        if (p <= 23) begin
            q = m << (23 - p);
        end else begin
            sh   = p - 23;
            q    = m >> sh;
            rem  = m - (q << sh);
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if (q == (longint'(1) << 24)) begin
                q = q >> 1;
                p = p + 1;
            end
        end
        return {s, 8'(p + 127), q[22:0]};
    endfunction

    function automatic int ref_lat(input longint v);
        longint m;
        int     i, lz;
        m  = (v < 0) ? -v : v;
        if (m == 0) return 2;
        lz = 0;
        i  = W - 1;
        while (i >= 0 && ((m >> i) & 1) == 0) begin
            lz++;
            i--;
        end
        return 2 + lz;
    endfunction

    // ---------------- monitor ----------------
    always @(posedge clk or negedge rst) begin
        if (!rst) edge_cnt <= 0;
        else      edge_cnt <= edge_cnt + 1;
    end

    always @(negedge clk) begin
        logic [31:0] e;
        int          l;
        if (!rst) begin
            seen = 1'b0;
        end else if (intf.ready && !seen) begin
            seen = 1'b1;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready result=%08h", intf.result);
            end else begin
                e = exp_q.pop_front();
                l = lat_q.pop_front();
                checks++;
                if (intf.result !== e) begin
                    errors++;
                    $display("FAIL result got=%08h exp=%08h", intf.result, e);
                end
                checks++;
                if (edge_cnt != l) begin
                    errors++;
                    $display("FAIL latency got=%0d exp=%0d (result %08h)", edge_cnt, l, e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_idle(input string name);
        checks++;
        if (intf.ready !== 1'b0 || intf.result !== 32'h0) begin
            errors++;
            $display("FAIL %s ready=%b result=%08h exp ready=0 result=00000000",
                     name, intf.ready, intf.result);
        end
    endtask

    task automatic wait_ready(input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (intf.ready) return;
        end
        checks++;
        errors++;
        $display("FAIL ready_timeout got=no_ready exp=ready within %0d cycles", bound);
        if (exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            void'(lat_q.pop_front());
        end
    endtask

    task automatic run_conv(input logic [31:0] av, input logic [31:0] e,
                            input int lat, input bit scramble);
        @(negedge clk);
        #1 rst = 1'b0;
        intf.a = av;
        #1 check_idle("reset_outputs");
        @(negedge clk);
        #1 rst = 1'b1;
        exp_q.push_back(e);
        lat_q.push_back(lat);
        if (scramble) begin
            @(posedge clk);
            #1 intf.a = $urandom();
        end
        wait_ready(80);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] v;
        longint      sv;
        int          sel;

        intf.a = '0;
        #3;
        check_idle("power_on_reset");
        checks++;
        if (dbg_state !== ST_LOAD) begin
            errors++;
            $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_LOAD);
        end

        // Directed cases with hand-derived results and latencies.
        run_conv(32'd0,          32'h00000000, 2,  1'b1);
        run_conv(32'd1,          32'h3F800000, 33, 1'b1);
        run_conv(32'hFFFFFFFF,   32'hBF800000, 33, 1'b0);
        run_conv(32'h80000000,   32'hCF000000, 2,  1'b0);
        run_conv(32'd16777217,   32'h4B800000, 9,  1'b0);
        run_conv(32'd16777219,   32'h4B800002, 9,  1'b1);
        run_conv(32'd2147483647, 32'h4F000000, 3,  1'b0);

        // Mid-normalisation reset on a = 1, then restart with a = 5.
        @(negedge clk);
        #1 rst = 1'b0;
        intf.a = 32'd1;
        @(negedge clk);
        #1 rst = 1'b1;
        repeat (10) @(posedge clk);
        #1 check_idle("mid_norm_not_ready");
        rst = 1'b0;
        #1 check_idle("mid_norm_reset");
        intf.a = 32'd5;
        @(negedge clk);
        #1 rst = 1'b1;
        exp_q.push_back(32'h40A00000);
        lat_q.push_back(31);
        wait_ready(80);

        // Release pulse shorter than a cycle: no LOAD, outputs stay reset.
        @(negedge clk);
        #1 rst = 1'b0;
        intf.a = 32'd7;
        @(negedge clk);
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("short_release");

        // Random operands: full range and shortened magnitudes of both signs.
        for (int n = 0; n < 100; n++) begin
            sel = $urandom_range(0, 2);
            v   = $urandom();
            if (sel == 1) v = v >> $urandom_range(0, 31);
            if (sel == 2) v = -(v >> $urandom_range(1, 31));
            sv = longint'($signed(v));
            run_conv(v, ref_f32(sv), ref_lat(sv), n[0]);
        end

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_expected got=%0d exp=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
